// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter with grant timeout; ports clock/n_reset, request->grant pulse, begin/end/bus_errorIN tracking, granted_id, bus_busy, grant_timeout, s_arb_cur_state
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int GRANT_TIMEOUT = 16,
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int CW = $clog2(GRANT_TIMEOUT) + 1
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  input  logic                   begin_transactionIN,
  input  logic                   end_transactionIN,
  input  logic                   bus_errorIN,
  output logic [IW-1:0]          granted_id,
  output logic                   bus_busy,
  output logic                   grant_timeout,
  output logic [1:0]             s_arb_cur_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAIT_BEGIN = 2'd2, BUSY = 2'd3} state_t;
  state_t state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0] granted_id_q, granted_id_d, last_q, last_d, win;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic bus_busy_q, bus_busy_d, grant_timeout_q, grant_timeout_d;
  logic unused_bus_error;
  int idx;
  assign unused_bus_error = bus_errorIN;
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_MASTERS;
      if (request[idx]) win = IW'(idx);
    end
    cnt_inc = cnt_q + CW'(cnt_q != '1);
    state_d = state_q;
    grant_d = '0;
    granted_id_d = granted_id_q;
    last_d = last_q;
    cnt_d = cnt_q;
    grant_timeout_d = 1'b0;
    case (state_q)
      IDLE: if (|request) begin
        grant_d = NUM_MASTERS'(1) << win;
        granted_id_d = win;
        last_d = win;
        state_d = GRANT;
      end
      GRANT: begin
        cnt_d = '0;
        state_d = WAIT_BEGIN;
      end
      WAIT_BEGIN: begin
        cnt_d = cnt_inc;
        if (begin_transactionIN) state_d = end_transactionIN ? IDLE : BUSY;
        else if (cnt_inc >= CW'(GRANT_TIMEOUT - 1)) begin
          state_d = IDLE;
          grant_timeout_d = 1'b1;
        end
      end
      default: state_d = end_transactionIN ? IDLE : BUSY;
    endcase
    bus_busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      granted_id_q <= '0;
      last_q <= IW'(NUM_MASTERS - 1);
      cnt_q <= '0;
      bus_busy_q <= 1'b0;
      grant_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      granted_id_q <= granted_id_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      bus_busy_q <= bus_busy_d;
      grant_timeout_q <= grant_timeout_d;
    end
  end
  assign grant = grant_q;
  assign granted_id = granted_id_q;
  assign bus_busy = bus_busy_q;
  assign grant_timeout = grant_timeout_q;
  assign s_arb_cur_state = state_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: scoreboard bench for bus_arbiter_rr (4-master and 2-master instances)
module tb_bus_arbiter_rr;
  logic clock = 1'b0;
  logic n_reset = 1'b0;
  logic [3:0] request = '0;
  logic [3:0] grant;
  logic begin_t = 1'b0, end_t = 1'b0, bus_err = 1'b0;
  logic [1:0] granted_id;
  logic bus_busy, grant_timeout;
  logic [1:0] state;
  logic [1:0] r2 = '0, g2, st2;
  logic b2 = 1'b0, e2 = 1'b0;
  logic id2, busy2, to2;
  int checks = 0, errors = 0;
  int exp_q[$], exp2_q[$];
  int n, ok;
  always #5 clock = ~clock;
  bus_arbiter_rr #(.NUM_MASTERS(4), .GRANT_TIMEOUT(16)) u_dut (
    .clock(clock), .n_reset(n_reset), .request(request), .grant(grant),
    .begin_transactionIN(begin_t), .end_transactionIN(end_t), .bus_errorIN(bus_err),
    .granted_id(granted_id), .bus_busy(bus_busy), .grant_timeout(grant_timeout),
    .s_arb_cur_state(state)
  );
  bus_arbiter_rr #(.NUM_MASTERS(2), .GRANT_TIMEOUT(16)) u_dut2 (
    .clock(clock), .n_reset(n_reset), .request(r2), .grant(g2),
    .begin_transactionIN(b2), .end_transactionIN(e2), .bus_errorIN(1'b0),
    .granted_id(id2), .bus_busy(busy2), .grant_timeout(to2),
    .s_arb_cur_state(st2)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic wait_grant(input int lim, output int cnt);
    cnt = 0;
    do begin
      cyc();
      @(negedge clock);
      cnt++;
    end while (grant == '0 && cnt < lim);
    check("grant_seen", 32'(grant != '0), 1);
  endtask
  task automatic xact(input int b, input int e);
    repeat (b) cyc();
    begin_t = 1'b1;
    cyc();
    begin_t = 1'b0;
    repeat (e - b - 1) cyc();
    end_t = 1'b1;
    @(negedge clock);
    check("xact_state_busy", 32'(state), 3);
    check("xact_bus_busy", 32'(bus_busy), 1);
    cyc();
    end_t = 1'b0;
    @(negedge clock);
    check("xact_state_idle", 32'(state), 0);
    check("xact_bus_free", 32'(bus_busy), 0);
  endtask
  always @(negedge clock) begin
    int e;
    if (grant != '0) begin
      check("grant_onehot", 32'($onehot0(grant)), 1);
      if (exp_q.size() == 0) check("grant_unexpected", 32'(grant), 0);
      else begin
        e = exp_q.pop_front();
        check("grant_vec", 32'(grant), 32'(1) << e);
        check("granted_id", 32'(granted_id), 32'(e));
      end
    end
  end
  always @(negedge clock) begin
    int e;
    if (g2 != '0) begin
      check("n2_grant_onehot", 32'($onehot0(g2)), 1);
      if (exp2_q.size() == 0) check("n2_grant_unexpected", 32'(g2), 0);
      else begin
        e = exp2_q.pop_front();
        check("n2_grant_vec", 32'(g2), 32'(1) << e);
        check("n2_granted_id", 32'(id2), 32'(e));
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (3) cyc();
    n_reset = 1'b1;
    @(negedge clock);
    check("rst_state", 32'(state), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(bus_busy), 0);
    check("rst_timeout", 32'(grant_timeout), 0);
    check("rst_id", 32'(granted_id), 0);
    exp_q.push_back(0);
    request = 4'b0001;
    wait_grant(4, n);
    check("t1_latency", 32'(n), 1);
    check("t1_busy_at_grant", 32'(bus_busy), 1);
    check("t1_state_grant", 32'(state), 1);
    request = '0;
    cyc();
    @(negedge clock);
    check("t1_state_wait", 32'(state), 2);
    xact(1, 5);
    request = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k + 1) % 4);
      wait_grant(4, n);
      check("t2_turnaround", 32'(n), 1);
      if (k == 3) request = '0;
      xact(2, 4);
    end
    exp_q.push_back(2);
    request = 4'b1100;
    wait_grant(4, n);
    request = 4'b1000;
    ok = 1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      @(negedge clock);
      if (grant_timeout || state != 2'd2) ok = 0;
    end
    check("t3_wait_hold", 32'(ok), 1);
    cyc();
    @(negedge clock);
    check("t3_timeout_pulse", 32'(grant_timeout), 1);
    check("t3_state_idle", 32'(state), 0);
    exp_q.push_back(3);
    wait_grant(4, n);
    check("t3_next_latency", 32'(n), 1);
    check("t3_timeout_cleared", 32'(grant_timeout), 0);
    request = '0;
    cyc();
    begin_t = 1'b1;
    end_t = 1'b1;
    @(negedge clock);
    check("t4_state_wait", 32'(state), 2);
    cyc();
    begin_t = 1'b0;
    end_t = 1'b0;
    @(negedge clock);
    check("t4_begin_end_idle", 32'(state), 0);
    check("t4_begin_end_free", 32'(bus_busy), 0);
    begin_t = 1'b1;
    end_t = 1'b1;
    cyc();
    begin_t = 1'b0;
    end_t = 1'b0;
    @(negedge clock);
    check("t4_stray_idle", 32'(state), 0);
    exp_q.push_back(0);
    request = 4'b0001;
    wait_grant(4, n);
    request = '0;
    cyc();
    begin_t = 1'b1;
    cyc();
    begin_t = 1'b0;
    bus_err = 1'b1;
    @(negedge clock);
    check("t4_err_busy", 32'(state), 3);
    cyc();
    bus_err = 1'b0;
    @(negedge clock);
    check("t4_err_still_busy", 32'(state), 3);
    cyc();
    end_t = 1'b1;
    cyc();
    end_t = 1'b0;
    @(negedge clock);
    check("t4_err_end_idle", 32'(state), 0);
    exp_q.push_back(1);
    request = 4'b0010;
    wait_grant(4, n);
    request = 4'b0100;
    cyc();
    begin_t = 1'b1;
    cyc();
    begin_t = 1'b0;
    @(negedge clock);
    check("t5_pre_rst_busy", 32'(state), 3);
    n_reset = 1'b0;
    cyc();
    @(negedge clock);
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_busy", 32'(bus_busy), 0);
    check("t5_rst_state", 32'(state), 0);
    n_reset = 1'b1;
    exp_q.push_back(2);
    wait_grant(4, n);
    check("t5_latency", 32'(n), 1);
    request = '0;
    xact(1, 3);
    exp2_q.push_back(0);
    r2 = 2'b01;
    cyc();
    @(negedge clock);
    check("n2_grant_seen", 32'(g2 != '0), 1);
    r2 = '0;
    cyc();
    r2 = 2'b10;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clock);
      if (g2 != '0 || st2 != 2'd2) ok = 0;
    end
    check("n2_no_grant_in_wait", 32'(ok), 1);
    b2 = 1'b1;
    cyc();
    b2 = 1'b0;
    @(negedge clock);
    check("n2_state_busy", 32'(st2), 3);
    e2 = 1'b1;
    cyc();
    e2 = 1'b0;
    @(negedge clock);
    check("n2_state_idle", 32'(st2), 0);
    exp2_q.push_back(1);
    cyc();
    @(negedge clock);
    check("n2_regrant_seen", 32'(g2 != '0), 1);
    r2 = '0;
    repeat (20) cyc();
    @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("n2_scoreboard_empty", 32'(exp2_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
